// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver states, oversampling
// ratio and the baud divider calculation.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // Rounded clocks-per-oversample-tick, integer arithmetic only.
  function automatic int calc_div(input int clk_freq, input int baud);
    return (clk_freq + (OVERSAMPLE * baud) / 2) / (OVERSAMPLE * baud);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through byte FIFO. A push into a full FIFO is dropped and
// flagged unless a pop in the same cycle frees the slot.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     not_empty,
  output logic                     overrun,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             empty, full, do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = push && !do_push;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage needs no reset; the head output is forced to zero while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = empty ? '0 : mem_q[rd_ptr_q];
  assign not_empty = !empty;
  assign overrun   = overrun_q;
  assign count     = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a byte FIFO; reports bad
// stop bits and bytes lost to a full FIFO as single-cycle pulses.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50000000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   rxd,
  output logic [7:0]             m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   frame_err,
  output logic                   overrun,
  output logic [$clog2(DEPTH):0] count
);

  localparam int DIV  = calc_div(CLK_FREQ, BAUD);
  localparam int TW   = $clog2(DIV + 1);
  localparam int OS_W = $clog2(OVERSAMPLE);

  logic            rxd_meta_q, rxd_sync_q;
  logic [TW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [OS_W-1:0] os_cnt_q, os_cnt_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  rx_state_t       state_q, state_d;
  logic            brk_q, brk_d;
  logic            frame_err_q, frame_err_d;
  logic            tick, push;

  assign tick = (tick_cnt_q == TW'(DIV - 1));

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    os_cnt_d    = tick ? os_cnt_q + 1'b1 : os_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    brk_d       = brk_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        os_cnt_d = '0;
        if (!rxd_sync_q) begin
          state_d    = START;
          tick_cnt_d = '0;
        end
      end
      START: begin
        if (tick && os_cnt_q == OS_W'(OVERSAMPLE / 2 - 1)) begin
          os_cnt_d  = '0;
          bit_cnt_d = '0;
          state_d   = rxd_sync_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
          shift_d   = {rxd_sync_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        // After a bad stop bit, a held-low line is a break: wait for idle.
        if (brk_q) begin
          if (rxd_sync_q) begin
            brk_d   = 1'b0;
            state_d = IDLE;
          end
        end else if (tick && os_cnt_q == OS_W'(OVERSAMPLE - 1)) begin
          if (rxd_sync_q) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            brk_d       = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      tick_cnt_q  <= '0;
      os_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      state_q     <= IDLE;
      brk_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rxd_meta_q  <= rxd;
      rxd_sync_q  <= rxd_meta_q;
      tick_cnt_q  <= tick_cnt_d;
      os_cnt_q    <= os_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      state_q     <= state_d;
      brk_q       <= brk_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;

  sync_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(8)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (shift_q),
    .pop       (m_valid && m_ready),
    .head_data (m_data),
    .not_empty (m_valid),
    .overrun   (overrun),
    .count     (count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames at the nominal bit rate, a monitor
// that logs pops and pulses, and a byte-queue model of what should arrive.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 8;
  localparam int BIT   = 434;
  localparam int TICK  = 27;

  typedef struct {
    logic [7:0] data;
    int         stop_low;
    int         exp_fe;
    logic       exp_byte;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n, rxd, m_ready, m_valid, frame_err, overrun;
  logic [7:0] m_data;
  logic [3:0] count;
  logic       man_ready, rand_ready_en;
  logic       rand_ready = 1'b0;

  int         fe_cnt = 0, ov_cnt = 0, valid_cyc = 0, stab_err = 0, inv_err = 0;
  logic [7:0] rx_q [$];
  logic       hold_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;

  int         n_checks = 0, n_fail = 0, rd_idx = 0;
  logic [7:0] exp_q [$];
  vec_t       vecs [3];
  int         fe0, ov0, vc0, found, nfe_exp;
  logic [7:0] d;
  logic       bad;

  assign m_ready = rand_ready_en ? rand_ready : man_ready;

  uart_rx_fifo #(
    .CLK_FREQ(50000000),
    .BAUD    (115200),
    .DEPTH   (DEPTH)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .rxd      (rxd),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .frame_err(frame_err),
    .overrun  (overrun),
    .count    (count)
  );

  always #10 clk = ~clk;

  always @(posedge clk) rand_ready <= 1'($urandom_range(0, 1));

  // Observe the consumer side halfway through each cycle.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (frame_err) fe_cnt <= fe_cnt + 1;
      if (overrun) ov_cnt <= ov_cnt + 1;
      if (m_valid) valid_cyc <= valid_cyc + 1;
      if (m_valid && m_ready) rx_q.push_back(m_data);
      if (hold_prev && m_data !== prev_data) stab_err <= stab_err + 1;
      if (m_valid !== (count != 4'd0)) inv_err <= inv_err + 1;
      hold_prev <= m_valid && !m_ready;
      prev_data <= m_data;
    end else begin
      hold_prev <= 1'b0;
    end
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // One 8N1 frame; stop_low > 0 holds the line low for that many bit times
  // in place of the stop bit, then returns it high for one bit time.
  task automatic applyStimulus(input logic [7:0] data, input int stop_low);
    rxd = 1'b0;
    tick_wait(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = data[i];
      tick_wait(BIT);
    end
    if (stop_low > 0) begin
      rxd = 1'b0;
      tick_wait(BIT * stop_low);
    end
    rxd = 1'b1;
    tick_wait(BIT);
  endtask

  task automatic checkBytes(input string tag);
    checkOutput({tag, " byte count"}, rx_q.size() - rd_idx, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (rd_idx < rx_q.size()) begin
        checkOutput($sformatf("%s byte %0d", tag, i), rx_q[rd_idx], exp_q[i]);
        rd_idx++;
      end
    end
    rd_idx = rx_q.size();
    exp_q.delete();
  endtask

  initial begin
    vecs[0] = '{8'h55, 0, 0, 1'b1};
    vecs[1] = '{8'hA3, 2, 1, 1'b0};
    vecs[2] = '{8'h3C, 0, 0, 1'b1};

    reset_n = 1'b0; rxd = 1'b1; man_ready = 1'b0; rand_ready_en = 1'b0;
    tick_wait(4);
    checkOutput("reset m_valid", m_valid, 0);
    checkOutput("reset m_data", m_data, 0);
    checkOutput("reset count", count, 0);
    checkOutput("reset frame_err", frame_err, 0);
    checkOutput("reset overrun", overrun, 0);
    checkOutput("reset state", dut.state_q, IDLE);
    reset_n = 1'b1; man_ready = 1'b1;
    tick_wait(4);

    // Single frames with the consumer always ready.
    for (int v = 0; v < 3; v++) begin
      fe0 = fe_cnt; ov0 = ov_cnt; vc0 = valid_cyc;
      applyStimulus(vecs[v].data, vecs[v].stop_low);
      tick_wait(8);
      if (vecs[v].exp_byte) exp_q.push_back(vecs[v].data);
      checkBytes($sformatf("vec%0d", v));
      checkOutput($sformatf("vec%0d frame_err pulses", v), fe_cnt - fe0, vecs[v].exp_fe);
      checkOutput($sformatf("vec%0d overrun pulses", v), ov_cnt - ov0, 0);
      checkOutput($sformatf("vec%0d m_valid cycles", v), valid_cyc - vc0, 32'(vecs[v].exp_byte));
      checkOutput($sformatf("vec%0d count", v), count, 0);
    end

    // Start-bit glitch: low for four oversample ticks only.
    fe0 = fe_cnt; ov0 = ov_cnt; vc0 = valid_cyc;
    rxd = 1'b0;
    tick_wait(4 * TICK);
    rxd = 1'b1;
    tick_wait(BIT);
    checkOutput("glitch state", dut.state_q, IDLE);
    checkOutput("glitch m_valid cycles", valid_cyc - vc0, 0);
    checkOutput("glitch frame_err pulses", fe_cnt - fe0, 0);
    checkOutput("glitch overrun pulses", ov_cnt - ov0, 0);

    // Fill with 0x00..0x07, then 0x08 must be dropped.
    man_ready = 1'b0;
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(8'(i), 0);
      if (i == 7) begin
        tick_wait(4);
        checkOutput("count after 8 frames", count, DEPTH);
        checkOutput("overrun before 9th", ov_cnt - ov0, 0);
      end
    end
    tick_wait(4);
    checkOutput("overrun pulses after 9th", ov_cnt - ov0, 1);
    checkOutput("count after 9th", count, DEPTH);
    checkOutput("head after overrun", m_data, 8'h00);
    checkOutput("frame_err while filling", fe_cnt - fe0, 0);

    // Push 0x09 into a full FIFO while popping in the same cycle.
    ov0 = ov_cnt;
    found = 0;
    fork
      applyStimulus(8'h09, 0);
      begin
        for (int c = 0; c < 6000 && found == 0; c++) begin
          tick_wait(1);
          if (dut.push) begin
            man_ready = 1'b1;
            found = 1;
            tick_wait(1);
            man_ready = 1'b0;
          end
        end
      end
    join
    checkOutput("push seen while full", found, 1);
    tick_wait(4);
    checkOutput("count after push+pop full", count, DEPTH);
    checkOutput("overrun on push+pop full", ov_cnt - ov0, 0);
    checkOutput("head after push+pop full", m_data, 8'h01);

    man_ready = 1'b1;
    tick_wait(7);
    man_ready = 1'b0;
    tick_wait(2);
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
    checkBytes("full drain");
    checkOutput("count before reset", count, 1);
    checkOutput("head before reset", m_data, 8'h09);

    // Reset in the middle of bit 4 of 0xFF, with 0x09 still queued.
    fe0 = fe_cnt; ov0 = ov_cnt;
    rxd = 1'b0;
    tick_wait(BIT);
    rxd = 1'b1;
    tick_wait(4 * BIT + BIT / 2);
    reset_n = 1'b0;
    tick_wait(3);
    checkOutput("midframe reset m_valid", m_valid, 0);
    checkOutput("midframe reset m_data", m_data, 0);
    checkOutput("midframe reset count", count, 0);
    checkOutput("midframe reset frame_err", frame_err, 0);
    checkOutput("midframe reset overrun", overrun, 0);
    checkOutput("midframe reset state", dut.state_q, IDLE);
    reset_n = 1'b1;
    tick_wait(BIT);
    man_ready = 1'b1;
    applyStimulus(8'h81, 0);
    tick_wait(8);
    exp_q.push_back(8'h81);
    checkBytes("after reset");
    checkOutput("after reset frame_err pulses", fe_cnt - fe0, 0);
    checkOutput("after reset overrun pulses", ov_cnt - ov0, 0);
    checkOutput("after reset count", count, 0);

    // Random bytes, occasional bad stop bit, random consumer back-pressure.
    fe0 = fe_cnt; ov0 = ov_cnt; nfe_exp = 0;
    rand_ready_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      d   = 8'($urandom_range(0, 255));
      bad = ($urandom_range(0, 3) == 0);
      applyStimulus(d, bad ? 1 : 0);
      if (bad) nfe_exp++;
      else exp_q.push_back(d);
    end
    rand_ready_en = 1'b0;
    man_ready = 1'b1;
    tick_wait(8);
    checkBytes("random");
    checkOutput("random frame_err pulses", fe_cnt - fe0, nfe_exp);
    checkOutput("random overrun pulses", ov_cnt - ov0, 0);
    checkOutput("random count", count, 0);

    checkOutput("m_data held while stalled", stab_err, 0);
    checkOutput("m_valid tracks count", inv_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
